// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Single-entry pipeline register that decodes one RV32I instruction word into
// register indices, a sign-extended immediate and control flags.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake
//   in_instr, in_pc         raw instruction word and its PC
//   flush                   drop the held bundle and the incoming instruction
//   out_valid / out_ready   downstream handshake
//   pc_out .. illegal_out   registered decoded bundle
//
// Handshake: a transfer happens on a rising edge when valid && ready are both
// high on that side. in_ready = !out_valid || out_ready, so the stage accepts
// when empty or when its bundle leaves on the same edge (one per cycle). While
// out_valid && !out_ready every output holds. flush wins over in_valid and
// out_ready: out_valid clears and nothing is accepted on that edge.
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN         = 32,
    parameter bit RD0_NO_WRITE = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc_out,
    output logic [6:0]      opcode_out,
    output logic [2:0]      funct3_out,
    output logic [6:0]      funct7_out,
    output logic [4:0]      rd_sel_out,
    output logic [4:0]      rs1_sel_out,
    output logic [4:0]      rs2_sel_out,
    output logic [XLEN-1:0] imm_value_out,
    output logic            imm_sel_out,
    output logic            write_enable_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic            branch_out,
    output logic            jump_out,
    output logic            illegal_out
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic            imm_sel;
        logic            write_enable;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            illegal;
    } bundle_t;

    bundle_t d_bun;
    bundle_t q_bun;
    logic    q_valid;
    logic    accept;

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            r_legal;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // All immediates sign-extend from instr[31].
    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};

    // funct7=0100000 only exists for SUB and SRA.
    assign r_legal = (funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

    always_comb begin
        d_bun        = '0;
        d_bun.pc     = in_pc;
        d_bun.opcode = opcode;
        unique case (opcode)
            OP_R: begin
                d_bun.funct3 = funct3;
                d_bun.funct7 = funct7;
                d_bun.rd     = in_instr[11:7];
                d_bun.rs1    = in_instr[19:15];
                d_bun.rs2    = in_instr[24:20];
                if (r_legal) d_bun.write_enable = 1'b1;
                else         d_bun.illegal      = 1'b1;
            end
            OP_IMM: begin
                d_bun.funct3       = funct3;
                d_bun.rd           = in_instr[11:7];
                d_bun.rs1          = in_instr[19:15];
                d_bun.imm          = imm_i;
                d_bun.imm_sel      = 1'b1;
                d_bun.write_enable = 1'b1;
                // Shift-immediates carry funct7 (SRLI vs SRAI).
                if ((funct3 == 3'b001) || (funct3 == 3'b101)) d_bun.funct7 = funct7;
            end
            OP_LOAD: begin
                d_bun.funct3       = funct3;
                d_bun.rd           = in_instr[11:7];
                d_bun.rs1          = in_instr[19:15];
                d_bun.imm          = imm_i;
                d_bun.imm_sel      = 1'b1;
                d_bun.write_enable = 1'b1;
                d_bun.mem_read     = 1'b1;
            end
            OP_JALR: begin
                d_bun.funct3       = funct3;
                d_bun.rd           = in_instr[11:7];
                d_bun.rs1          = in_instr[19:15];
                d_bun.imm          = imm_i;
                d_bun.imm_sel      = 1'b1;
                d_bun.write_enable = 1'b1;
                d_bun.jump         = 1'b1;
            end
            OP_STORE: begin
                d_bun.funct3    = funct3;
                d_bun.rs1       = in_instr[19:15];
                d_bun.rs2       = in_instr[24:20];
                d_bun.imm       = imm_s;
                d_bun.imm_sel   = 1'b1;
                d_bun.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                d_bun.funct3 = funct3;
                d_bun.rs1    = in_instr[19:15];
                d_bun.rs2    = in_instr[24:20];
                d_bun.imm    = imm_b;
                d_bun.branch = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                d_bun.rd           = in_instr[11:7];
                d_bun.imm          = imm_u;
                d_bun.imm_sel      = 1'b1;
                d_bun.write_enable = 1'b1;
            end
            OP_JAL: begin
                d_bun.rd           = in_instr[11:7];
                d_bun.imm          = imm_j;
                d_bun.imm_sel      = 1'b1;
                d_bun.write_enable = 1'b1;
                d_bun.jump         = 1'b1;
            end
            // Unknown opcodes, including any with instr[1:0] != 2'b11.
            default: d_bun.illegal = 1'b1;
        endcase
        if (RD0_NO_WRITE && (d_bun.rd == 5'd0)) d_bun.write_enable = 1'b0;
    end

    assign in_ready = !q_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_bun   <= '0;
        end else if (flush) begin
            q_valid <= 1'b0;
        end else if (accept) begin
            q_valid <= 1'b1;
            q_bun   <= d_bun;
        end else if (out_ready) begin
            q_valid <= 1'b0;
        end
    end

    assign out_valid        = q_valid;
    assign pc_out           = q_bun.pc;
    assign opcode_out       = q_bun.opcode;
    assign funct3_out       = q_bun.funct3;
    assign funct7_out       = q_bun.funct7;
    assign rd_sel_out       = q_bun.rd;
    assign rs1_sel_out      = q_bun.rs1;
    assign rs2_sel_out      = q_bun.rs2;
    assign imm_value_out    = q_bun.imm;
    assign imm_sel_out      = q_bun.imm_sel;
    assign write_enable_out = q_bun.write_enable;
    assign mem_read_out     = q_bun.mem_read;
    assign mem_write_out    = q_bun.mem_write;
    assign branch_out       = q_bun.branch;
    assign jump_out         = q_bun.jump;
    assign illegal_out      = q_bun.illegal;

endmodule
